mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/param_defs.sv | 11 +
 rtl/arb_starve_cnt.sv | 26 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_defs.sv
// Shared types and widths for the instruction/data memory port arbiter.
package param_defs;
   localparam int MemBusWidth = 32;
   localparam int BeWidth     = 4;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_IF_ACC  = 2'd1,
      ARB_LSU_ACC = 2'd2
   } arb_state_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of arbitration points the fetch port has lost to the LSU.
// Registered count, one-cycle update; clear has priority over increment.
module arb_starve_cnt #(
   parameter int MaxIfWait = 4,
   parameter int CntWidth  = $clog2(MaxIfWait + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_inc,
   input  logic                i_clr,
   output logic [CntWidth-1:0] o_cnt
);
   logic [CntWidth-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CntWidth'(MaxIfWait))) begin
         r_cnt <= r_cnt + CntWidth'(1);
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / LSU) arbiter onto one memory port. Grant is combinational, access fields
// registered; rvalid one cycle after mem_ready. Requesters hold req until gnt; mem stalls via mem_ready.
module mem_port_arbiter
   import param_defs::*;
#(
   parameter int MaxIfWait = 4,
   parameter int AddrWidth = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   if_req,
   input  logic [AddrWidth-1:0]   if_addr,
   output logic                   if_gnt,
   output logic                   if_rvalid,
   output logic [MemBusWidth-1:0] if_rdata,
   input  logic                   lsu_req,
   input  logic                   lsu_we,
   input  logic [AddrWidth-1:0]   lsu_addr,
   input  logic [MemBusWidth-1:0] lsu_wdata,
   input  logic [BeWidth-1:0]     lsu_be,
   output logic                   lsu_gnt,
   output logic                   lsu_rvalid,
   output logic [MemBusWidth-1:0] lsu_rdata,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [AddrWidth-1:0]   mem_addr,
   output logic [MemBusWidth-1:0] mem_wdata,
   output logic [BeWidth-1:0]     mem_be,
   input  logic                   mem_ready,
   input  logic [MemBusWidth-1:0] mem_rdata
);
   localparam int CntWidth = $clog2(MaxIfWait + 1);

   arb_state_t             r_state;
   logic                   r_rst_done;
   logic [AddrWidth-1:0]   r_addr;
   logic                   r_we;
   logic [MemBusWidth-1:0] r_wdata;
   logic [BeWidth-1:0]     r_be;
   logic                   r_if_rvalid;
   logic                   r_lsu_rvalid;
   logic [MemBusWidth-1:0] r_if_rdata;
   logic [MemBusWidth-1:0] r_lsu_rdata;

   logic [CntWidth-1:0]    w_starve_cnt;
   logic                   w_busy;
   logic                   w_mem_done;
   logic                   w_arb_pt;
   logic                   w_if_win;
   logic                   w_if_gnt;
   logic                   w_lsu_gnt;

   // r_rst_done keeps grants off until the first clock edge after reset release.
   assign w_busy     = (r_state != ARB_IDLE);
   assign w_mem_done = w_busy && mem_ready;
   assign w_arb_pt   = r_rst_done && (!w_busy || mem_ready);
   assign w_if_win   = if_req && (!lsu_req || (w_starve_cnt >= CntWidth'(MaxIfWait)));
   assign w_if_gnt   = w_arb_pt && w_if_win;
   assign w_lsu_gnt  = w_arb_pt && lsu_req && !w_if_win;

   arb_starve_cnt #(
      .MaxIfWait (MaxIfWait),
      .CntWidth  (CntWidth)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_lsu_gnt && if_req),
      .i_clr (w_if_gnt || !if_req),
      .o_cnt (w_starve_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_done <= 1'b0;
         r_state    <= ARB_IDLE;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_be       <= '0;
      end else begin
         r_rst_done <= 1'b1;
         if (w_if_gnt) begin
            r_state <= ARB_IF_ACC;
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= {BeWidth{1'b1}};
         end else if (w_lsu_gnt) begin
            r_state <= ARB_LSU_ACC;
            r_addr  <= lsu_addr;
            r_we    <= lsu_we;
            r_wdata <= lsu_wdata;
            r_be    <= lsu_be;
         end else if (w_arb_pt) begin
            r_state <= ARB_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_rvalid  <= 1'b0;
         r_lsu_rvalid <= 1'b0;
         r_if_rdata   <= '0;
         r_lsu_rdata  <= '0;
      end else begin
         r_if_rvalid  <= w_mem_done && (r_state == ARB_IF_ACC);
         r_lsu_rvalid <= w_mem_done && (r_state == ARB_LSU_ACC);
         if (w_mem_done && (r_state == ARB_IF_ACC)) begin
            r_if_rdata <= mem_rdata;
         end
         // Store completion returns zero data so the LSU never sees stale bus contents.
         if (w_mem_done && (r_state == ARB_LSU_ACC)) begin
            r_lsu_rdata <= r_we ? '0 : mem_rdata;
         end
      end
   end

   assign if_gnt     = w_if_gnt;
   assign lsu_gnt    = w_lsu_gnt;
   assign if_rvalid  = r_if_rvalid;
   assign if_rdata   = r_if_rdata;
   assign lsu_rvalid = r_lsu_rvalid;
   assign lsu_rdata  = r_lsu_rdata;
   assign mem_req    = w_busy;
   assign mem_we     = r_we && (r_state == ARB_LSU_ACC);
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
   assign mem_be     = r_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed latency/reset scenarios plus random traffic,
// scored against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
   import param_defs::*;

   localparam int MAX_WAIT = 4;
   localparam int AW       = 32;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   if_req = 1'b0;
   logic [AW-1:0]          if_addr = '0;
   logic                   if_gnt, if_rvalid;
   logic [MemBusWidth-1:0] if_rdata;
   logic                   lsu_req = 1'b0;
   logic                   lsu_we = 1'b0;
   logic [AW-1:0]          lsu_addr = '0;
   logic [MemBusWidth-1:0] lsu_wdata = '0;
   logic [3:0]             lsu_be = '0;
   logic                   lsu_gnt, lsu_rvalid;
   logic [MemBusWidth-1:0] lsu_rdata;
   logic                   mem_req, mem_we;
   logic [AW-1:0]          mem_addr;
   logic [MemBusWidth-1:0] mem_wdata;
   logic [3:0]             mem_be;
   logic                   mem_ready = 1'b0;
   logic [MemBusWidth-1:0] mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MaxIfWait(MAX_WAIT), .AddrWidth(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_be(lsu_be), .lsu_gnt(lsu_gnt),
      .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   // Memory contents are a fixed function of address, so expected read data is known at grant.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction
   assign mem_rdata = memf(mem_addr);

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        is_if;
   } acc_t;

   acc_t        mem_q[$];
   logic [31:0] if_q[$];
   logic [31:0] lsu_q[$];
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_nonempty(input string nm, input int sz);
      tests++;
      if (sz == 0) begin
         fails++;
         $display("FAIL %s: response with no outstanding expectation (t=%0t)", nm, $time);
      end
   endtask

   // Model state: one access in flight at most; loss = consecutive arbitrations the fetch lost.
   int   outstanding = 0;
   int   loss = 0;
   logic pend_if = 1'b0, pend_lsu = 1'b0;
   logic m_arb, m_done, m_eif, m_elsu;
   acc_t m_a;

   always @(negedge clk) begin
      if (!rst_n) begin
         mem_q.delete(); if_q.delete(); lsu_q.delete();
         outstanding = 0; loss = 0; pend_if = 1'b0; pend_lsu = 1'b0;
      end else begin
         chk("if_rvalid", if_rvalid, pend_if);
         chk("lsu_rvalid", lsu_rvalid, pend_lsu);
         if (if_rvalid) begin
            chk_nonempty("if_q", if_q.size());
            if (if_q.size() != 0) chk("if_rdata", if_rdata, if_q.pop_front());
         end
         if (lsu_rvalid) begin
            chk_nonempty("lsu_q", lsu_q.size());
            if (lsu_q.size() != 0) chk("lsu_rdata", lsu_rdata, lsu_q.pop_front());
         end
         chk("mem_req", mem_req, outstanding != 0);
         chk("gnt_excl", if_gnt & lsu_gnt, 1'b0);

         m_done   = (outstanding != 0) && mem_ready;
         pend_if  = 1'b0;
         pend_lsu = 1'b0;
         if (m_done) begin
            chk_nonempty("mem_q", mem_q.size());
            if (mem_q.size() != 0) begin
               m_a = mem_q.pop_front();
               chk("mem_addr", mem_addr, m_a.addr);
               chk("mem_we", mem_we, m_a.we);
               chk("mem_be", mem_be, m_a.be);
               if (m_a.we) chk("mem_wdata", mem_wdata, m_a.wdata);
               pend_if  = m_a.is_if;
               pend_lsu = !m_a.is_if;
            end
         end

         m_arb  = (outstanding == 0) || mem_ready;
         m_eif  = m_arb && if_req && (!lsu_req || loss >= MAX_WAIT);
         m_elsu = m_arb && lsu_req && !m_eif;
         chk("if_gnt", if_gnt, m_eif);
         chk("lsu_gnt", lsu_gnt, m_elsu);
         if (m_eif) begin
            mem_q.push_back('{addr: if_addr, we: 1'b0, wdata: 32'h0, be: 4'hF, is_if: 1'b1});
            if_q.push_back(memf(if_addr));
         end else if (m_elsu) begin
            mem_q.push_back('{addr: lsu_addr, we: lsu_we, wdata: lsu_wdata, be: lsu_be, is_if: 1'b0});
            lsu_q.push_back(lsu_we ? 32'h0 : memf(lsu_addr));
         end

         if (m_eif || m_elsu) outstanding = 1;
         else if (m_done) outstanding = 0;
         if (!if_req || m_eif) loss = 0;
         else if (m_elsu) loss = (loss < MAX_WAIT) ? loss + 1 : MAX_WAIT;
      end
   end

   task automatic cyc_drive;
      @(posedge clk); #1;
   endtask

   task automatic lone_fetch(input string tag);
      cyc_drive(); if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b0;
      @(negedge clk); chk({tag, "_gnt_c0"}, if_gnt, 1'b1); chk({tag, "_req_c0"}, mem_req, 1'b0);
      cyc_drive(); if_req = 1'b0;
      @(negedge clk); chk({tag, "_req_c1"}, mem_req, 1'b1);
      chk({tag, "_addr_c1"}, mem_addr, 32'h100); chk({tag, "_be_c1"}, mem_be, 4'hF);
      cyc_drive();
      @(negedge clk); chk({tag, "_req_c2"}, mem_req, 1'b1);
      cyc_drive(); mem_ready = 1'b1;
      @(negedge clk); chk({tag, "_req_c3"}, mem_req, 1'b1); chk({tag, "_rv_c3"}, if_rvalid, 1'b0);
      cyc_drive(); mem_ready = 1'b0;
      @(negedge clk); chk({tag, "_rv_c4"}, if_rvalid, 1'b1);
      chk({tag, "_rdata_c4"}, if_rdata, memf(32'h100)); chk({tag, "_req_c4"}, mem_req, 1'b0);
   endtask

   int   n_lsu, if_at;
   logic ig, lg;

   initial begin
      // Reset values, with requests asserted to show grants are suppressed.
      #3; if_req = 1'b1; lsu_req = 1'b1; #1;
      chk("rst_mem_req", mem_req, 1'b0);   chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 0);    chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);        chk("rst_if_gnt", if_gnt, 1'b0);
      chk("rst_lsu_gnt", lsu_gnt, 1'b0);   chk("rst_if_rv", if_rvalid, 1'b0);
      chk("rst_lsu_rv", lsu_rvalid, 1'b0); chk("rst_if_rdata", if_rdata, 0);
      chk("rst_lsu_rdata", lsu_rdata, 0);
      if_req = 1'b0; lsu_req = 1'b0;
      #18; rst_n = 1'b1;

      lone_fetch("lone");

      // Simultaneous requests: LSU first, fetch back-to-back on the LSU completion.
      cyc_drive(); if_req = 1'b1; if_addr = 32'h100;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h200;
      @(negedge clk); chk("sim_lsu_first", lsu_gnt, 1'b1); chk("sim_if_wait", if_gnt, 1'b0);
      cyc_drive(); lsu_req = 1'b0;
      @(negedge clk); chk("sim_addr_lsu", mem_addr, 32'h200); chk("sim_if_nogrant", if_gnt, 1'b0);
      cyc_drive(); mem_ready = 1'b1;
      @(negedge clk); chk("sim_if_b2b", if_gnt, 1'b1);
      cyc_drive(); if_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk); chk("sim_req_held", mem_req, 1'b1); chk("sim_addr_if", mem_addr, 32'h100);
      cyc_drive(); mem_ready = 1'b1;
      @(negedge clk);
      cyc_drive(); mem_ready = 1'b0;
      @(negedge clk); chk("sim_if_rv", if_rvalid, 1'b1);

      // Starvation: fetch must win on the fifth arbitration point.
      cyc_drive(); if_req = 1'b1; if_addr = 32'h400;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h500; mem_ready = 1'b1;
      n_lsu = 0; if_at = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (if_gnt) begin if_at = k; break; end
         if (lsu_gnt) n_lsu++;
         cyc_drive(); lsu_addr = lsu_addr + 32'h4;
      end
      chk("starve_if_at", if_at, MAX_WAIT);
      chk("starve_lsu_wins", n_lsu, MAX_WAIT);
      cyc_drive(); if_req = 1'b0; lsu_req = 1'b0;
      @(negedge clk); chk("starve_cnt_clr", dut.w_starve_cnt, 0);
      repeat (3) @(negedge clk);
      cyc_drive(); mem_ready = 1'b0;

      // Store with wait states.
      cyc_drive(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h300;
      lsu_wdata = 32'hDEADBEEF; lsu_be = 4'b0011;
      @(negedge clk); chk("st_gnt", lsu_gnt, 1'b1);
      cyc_drive(); lsu_req = 1'b0; lsu_wdata = 32'h0; lsu_we = 1'b0; lsu_be = 4'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("st_we", mem_we, 1'b1); chk("st_be", mem_be, 4'b0011);
         chk("st_wdata", mem_wdata, 32'hDEADBEEF); chk("st_addr", mem_addr, 32'h300);
         cyc_drive(); mem_ready = (k == 2);
      end
      @(negedge clk);
      cyc_drive(); mem_ready = 1'b0;
      @(negedge clk); chk("st_rv", lsu_rvalid, 1'b1); chk("st_rdata", lsu_rdata, 32'h0);

      // Reset while in the LSU access state.
      cyc_drive(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h600;
      @(negedge clk); chk("rs_gnt", lsu_gnt, 1'b1);
      cyc_drive(); lsu_req = 1'b0;
      @(negedge clk); chk("rs_req_on", mem_req, 1'b1);
      @(posedge clk); #3; rst_n = 1'b0; #1;
      chk("rs_req_async", mem_req, 1'b0); chk("rs_addr_async", mem_addr, 0);
      @(negedge clk); @(negedge clk); #2; rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); chk("rs_no_rv", lsu_rvalid, 1'b0);
      end
      lone_fetch("post_rst");

      // Spurious mem_ready in IDLE.
      cyc_drive(); mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("sp_if_rv", if_rvalid, 1'b0); chk("sp_lsu_rv", lsu_rvalid, 1'b0);
         chk("sp_req", mem_req, 1'b0);
      end
      cyc_drive(); mem_ready = 1'b0;

      // Random traffic scored by the monitor.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk); ig = if_gnt; lg = lsu_gnt;
         cyc_drive();
         if (ig) if_req = 1'b0;
         if (lg) lsu_req = 1'b0;
         if (!if_req && ($urandom_range(0, 1) == 1)) begin
            if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!lsu_req && ($urandom_range(0, 9) < 8)) begin
            lsu_req = 1'b1; lsu_we = $urandom_range(0, 1);
            lsu_addr = $urandom & 32'hFFFF_FFFC; lsu_wdata = $urandom;
            lsu_be = 4'($urandom_range(1, 15));
         end
         mem_ready = $urandom_range(0, 1);
      end
      @(negedge clk);
      cyc_drive(); if_req = 1'b0; lsu_req = 1'b0; mem_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("drain_mem_q", mem_q.size(), 0);
      chk("drain_if_q", if_q.size(), 0);
      chk("drain_lsu_q", lsu_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
